// File: rtl/bytecode_predecoder_if.sv
// Handshake and record bus of the bytecode predecoder: byte input side,
// flush control and decoded-record output side.
interface bytecode_predecoder_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16
) ();
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              flush;
  logic [PC_W-1:0]   flush_pc;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_opcode;
  logic [1:0]        out_len;
  logic [PC_W-1:0]   out_pc;
  logic [7:0]        out_index;
  logic [DATA_W-1:0] out_operand;
  logic [PC_W-1:0]   out_target;
  logic              out_isbranch;
  logic              out_illegal;

  modport master (
    output in_valid, in_byte, flush, flush_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_len, out_pc, out_index,
           out_operand, out_target, out_isbranch, out_illegal
  );

  modport slave (
    input  in_valid, in_byte, flush, flush_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_len, out_pc, out_index,
           out_operand, out_target, out_isbranch, out_illegal
  );
endinterface

// File: rtl/bytecode_predecoder.sv
// JVM-style bytecode predecoder: assembles 1..3 byte instructions from a byte
// stream and queues fully decoded records in a small FIFO.
module bytecode_predecoder #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bytecode_predecoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [1:0]        len;
    logic [PC_W-1:0]   pc;
    logic [7:0]        index;
    logic [DATA_W-1:0] operand;
    logic [PC_W-1:0]   target;
    logic              isbranch;
    logic              illegal;
  } rec_t;

  typedef enum logic [1:0] {S_OP, S_ARG1, S_ARG2} state_t;

  function automatic logic op_legal(input logic [7:0] op);
    return op inside {8'h00, [8'h02:8'h08], [8'h10:8'h12], 8'h15,
                      [8'h1A:8'h1D], [8'h2A:8'h2E], 8'h33, 8'h36,
                      [8'h3B:8'h3E], [8'h4B:8'h4F], 8'h54, 8'h57, 8'h59,
                      8'h60, 8'h64, 8'h68, 8'h6C, 8'h70, 8'h74, 8'h78,
                      8'h7A, 8'h7E, 8'h80, 8'h82, 8'h84, [8'h99:8'hA4],
                      8'hA7, 8'hAC, 8'hB0, 8'hB1};
  endfunction

  function automatic logic [1:0] op_len(input logic [7:0] op);
    if (!op_legal(op))
      return 2'd1;
    else if (op inside {8'h10, 8'h12, 8'h15, 8'h36})
      return 2'd2;
    else if (op inside {8'h11, 8'h84, [8'h99:8'hA4], 8'hA7})
      return 2'd3;
    else
      return 2'd1;
  endfunction

  function automatic logic op_branch(input logic [7:0] op);
    return op inside {[8'h99:8'hA4], 8'hA7};
  endfunction

  // Builds the full record from the opcode and whichever argument bytes exist;
  // missing argument bytes are passed as zero.
  function automatic rec_t build(input logic [7:0] op, input logic [7:0] a1,
                                 input logic [7:0] a2, input logic [PC_W-1:0] pc);
    rec_t              r;
    logic signed [15:0] imm16;
    logic signed [7:0]  s1;
    logic signed [7:0]  s2;
    logic signed [7:0]  k;
    r      = '0;
    r.opcode = op;
    r.pc     = pc;
    r.len    = op_len(op);
    imm16  = signed'({a1, a2});
    s1     = signed'(a1);
    s2     = signed'(a2);
    k      = signed'(8'(op - 8'd3));
    if (!op_legal(op)) begin
      r.illegal = 1'b1;
    end else begin
      if (op inside {[8'h02:8'h08]}) r.operand = DATA_W'(k);
      else if (op == 8'h10)          r.operand = DATA_W'(s1);
      else if (op == 8'h11)          r.operand = DATA_W'(imm16);
      else if (op == 8'h12)          r.operand = DATA_W'(a1);
      else if (op == 8'h84)          r.operand = DATA_W'(s2);

      if (op inside {8'h15, 8'h36, 8'h84})                r.index = a1;
      else if (op inside {[8'h1A:8'h1D], [8'h2A:8'h2D]})  r.index = {6'd0, 2'(op[1:0] - 2'd2)};
      else if (op inside {[8'h3B:8'h3E]})                 r.index = 8'(op - 8'h3B);
      else if (op inside {[8'h4B:8'h4E]})                 r.index = 8'(op - 8'h4B);

      if (op_branch(op)) begin
        r.isbranch = 1'b1;
        r.target   = PC_W'(pc + PC_W'(imm16));
      end
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   op_pc_q;
  logic [7:0]        op_q;
  logic [7:0]        a1_q;
  logic              run_q;
  rec_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic              accept, push, pop, latch_op, latch_a1;
  rec_t              push_rec;
  rec_t              head;

  // run_q keeps in_ready low throughout reset and the release cycle.
  assign bus.in_ready  = run_q && (count < CW'(DEPTH)) && !bus.flush;
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    latch_op = 1'b0;
    latch_a1 = 1'b0;
    push_rec = build(bus.in_byte, 8'd0, 8'd0, pc_q);
    unique case (state_q)
      S_OP: begin
        if (accept) begin
          latch_op = 1'b1;
          if (op_len(bus.in_byte) == 2'd1) push = 1'b1;
          else                             state_d = S_ARG1;
        end
      end
      S_ARG1: begin
        push_rec = build(op_q, bus.in_byte, 8'd0, op_pc_q);
        if (accept) begin
          latch_a1 = 1'b1;
          if (op_len(op_q) == 2'd2) begin
            push    = 1'b1;
            state_d = S_OP;
          end else begin
            state_d = S_ARG2;
          end
        end
      end
      S_ARG2: begin
        push_rec = build(op_q, a1_q, bus.in_byte, op_pc_q);
        if (accept) begin
          push    = 1'b1;
          state_d = S_OP;
        end
      end
      default: state_d = S_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state_q <= S_OP;
    else if (bus.flush) state_q <= S_OP;
    else                state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      pc_q    <= '0;
      op_pc_q <= '0;
      op_q    <= '0;
      a1_q    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      run_q <= 1'b1;
      if (bus.flush) begin
        pc_q   <= bus.flush_pc;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept)   pc_q <= PC_W'(pc_q + PC_W'(1));
        if (latch_op) begin
          op_q    <= bus.in_byte;
          op_pc_q <= pc_q;
        end
        if (latch_a1) a1_q <= bus.in_byte;
        if (push) begin
          mem[wr_ptr] <= push_rec;
          wr_ptr      <= AW'(wr_ptr + AW'(1));
        end
        if (pop) rd_ptr <= AW'(rd_ptr + AW'(1));
        if (push && !pop)      count <= CW'(count + CW'(1));
        else if (!push && pop) count <= CW'(count - CW'(1));
      end
    end
  end

  assign head             = mem[rd_ptr];
  assign bus.out_opcode   = head.opcode;
  assign bus.out_len      = head.len;
  assign bus.out_pc       = head.pc;
  assign bus.out_index    = head.index;
  assign bus.out_operand  = head.operand;
  assign bus.out_target   = head.target;
  assign bus.out_isbranch = head.isbranch;
  assign bus.out_illegal  = head.illegal;
endmodule
